// File: rtl/vend_coin_sched.sv
// Coin front-end for the cola vending core: queues coin pulses, issues them one at a time,
// then sequences dispense motor and change hopper. Optional vend counter: STAT_VEND_CNT_EN.
module vend_coin_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          coin_half_in,
  input  logic                          coin_one_in,
  output logic                          coin_rej_half,
  output logic                          coin_rej_one,
  output logic                          core_half,
  output logic                          core_one,
  input  logic                          core_cola,
  input  logic                          core_money,
  output logic                          disp_req,
  input  logic                          disp_ack,
  output logic                          change_req,
  input  logic                          change_ack,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [CNT_W-1:0]              vend_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, SAMPLE, DISPENSE, CHANGE} state_t;

  state_t          state, state_nxt;
  logic            pend_change;
  logic            mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            head, pop;
  logic [CW-1:0]   space;
  logic            acc_half, acc_one;
  logic            core_half_d, core_one_d, disp_req_d, change_req_d, busy_d;

  // Queue: entry 0 = half, 1 = one. Space counts the slot freed by a same-cycle pop.
  assign head     = mem[rd_ptr];
  assign pop      = (state == IDLE) && (fifo_cnt != '0);
  assign space    = CW'(FIFO_DEPTH) - fifo_cnt + CW'(pop);
  assign acc_half = coin_half_in && (space != '0);
  assign acc_one  = coin_one_in && (space > CW'(acc_half));

  // NOTE: storage is not reset; clearing the pointers and count already empties the queue.
  always_ff @(posedge clk) begin
    if (acc_half) mem[wr_ptr] <= 1'b0;
    if (acc_one)  mem[wr_ptr + AW'(acc_half)] <= 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_cnt      <= '0;
      coin_rej_half <= 1'b0;
      coin_rej_one  <= 1'b0;
    end else begin
      rd_ptr        <= rd_ptr + AW'(pop);
      wr_ptr        <= wr_ptr + AW'(acc_half) + AW'(acc_one);
      fifo_cnt      <= fifo_cnt + CW'(acc_half) + CW'(acc_one) - CW'(pop);
      coin_rej_half <= coin_half_in && !acc_half;
      coin_rej_one  <= coin_one_in && !acc_one;
    end
  end

  // State register plus registered outputs taken from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_change <= 1'b0;
      core_half   <= 1'b0;
      core_one    <= 1'b0;
      disp_req    <= 1'b0;
      change_req  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      core_half   <= core_half_d;
      core_one    <= core_one_d;
      disp_req    <= disp_req_d;
      change_req  <= change_req_d;
      busy        <= busy_d;
      if (state == SAMPLE && core_cola)
        pend_change <= core_money;
      else if (state == CHANGE && change_ack)
        pend_change <= 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pop) state_nxt = ISSUE;
      ISSUE:    state_nxt = SAMPLE;
      SAMPLE:   state_nxt = core_cola ? DISPENSE : IDLE;
      DISPENSE: if (disp_ack) state_nxt = pend_change ? CHANGE : IDLE;
      CHANGE:   if (change_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_half_d  = pop && !head;
    core_one_d   = pop && head;
    disp_req_d   = (state_nxt == DISPENSE);
    change_req_d = (state_nxt == CHANGE);
    busy_d       = (state_nxt != IDLE);
  end

`ifdef STAT_VEND_CNT_EN
  // Saturating count of completed dispenses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vend_cnt <= '0;
    else if (state == DISPENSE && disp_ack && vend_cnt != '1)
      vend_cnt <= vend_cnt + 1'b1;
  end
`else
  assign vend_cnt = '0;
`endif

endmodule

// File: doc/vend_coin_sched.md
Name: vend_coin_sched

Overview:
Front-end controller for the cola vending core (0.5/1.0 coin inputs, cola and change pulse outputs). Captures raw coin pulses from two acceptors into a small queue. Issues coins to the core strictly one at a time, so half and one are never presented together. Samples the core's registered result, then sequences the dispense motor and change hopper through req/ack handshakes, holding further coins until the vend completes.

Parameters:
FIFO_DEPTH, 4, coin queue entries; power of two, 2..16
CNT_W, 16, width of optional vend counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
coin_half_in  in  1  one-cycle pulse, 0.5 coin detected
coin_one_in  in  1  one-cycle pulse, 1.0 coin detected; may coincide with coin_half_in
coin_rej_half  out  1  one-cycle pulse, 0.5 coin refused (queue full)
coin_rej_one  out  1  one-cycle pulse, 1.0 coin refused (queue full)
core_half  out  1  to core pi_money_half
core_one  out  1  to core pi_money_one
core_cola  in  1  from core po_cola (registered, valid 1 cycle after core pulse)
core_money  in  1  from core po_money
disp_req  out  1  dispense motor request, level
disp_ack  in  1  dispense done
change_req  out  1  change hopper request, level
change_ack  in  1  change paid
busy  out  1  high in any state except IDLE
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  queued coins
vend_cnt  out  CNT_W  completed vends (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low. Reset clears queue, state=IDLE, pend_change=0. All outputs 0 during and after reset. Reset mid-handshake drops disp_req/change_req immediately. The core shares rst_n.
- Queue: 1-bit entries (0=half, 1=one).
  - Up to 2 writes per cycle; on coincident pulses half is written before one.
  - Free space 1 with 2 arrivals: half accepted, one refused.
  - Free space 0: both refused.
  - Refusal pulses are registered, 1 cycle after the arrival.
  - At most 1 pop per cycle. Pop and write in the same cycle is legal; space is computed after the pop.
  - fifo_cnt is registered and never exceeds FIFO_DEPTH.
- FSM states: IDLE, ISSUE, SAMPLE, DISPENSE, CHANGE.
  - IDLE: if queue non-empty, pop head; next state ISSUE with core_half or core_one registered high per entry.
  - ISSUE: exactly one of core_half/core_one high for exactly 1 cycle; next SAMPLE, core_* low.
  - SAMPLE: if core_cola=1, latch pend_change<=core_money, go DISPENSE with disp_req=1; else IDLE.
  - DISPENSE: hold disp_req until disp_ack sampled 1. Then drop disp_req; go CHANGE (change_req=1) if pend_change, else IDLE.
  - CHANGE: hold change_req until change_ack sampled 1; then drop it, clear pend_change, go IDLE.
  - Acks seen outside their state are ignored. core_money without core_cola is ignored (not reachable from a correct core).
- Latency: coin pulse at cycle 0 into an empty queue with FSM in IDLE: core pulse in cycle 2, result sampled in cycle 3, disp_req high from cycle 4. Non-vending coin throughput is 1 per 3 cycles.
- Coins arriving during DISPENSE/CHANGE are queued, not issued, until IDLE.
- busy is registered from the next state, so it aligns with state.

Optional Feature:
- Macro STAT_VEND_CNT_EN.
- Defined: vend_cnt increments by 1 on each DISPENSE exit (disp_ack accepted), saturates at all-ones, and is cleared by reset.
- Undefined: counter logic is not built; vend_cnt is tied to 0. The port remains present.

Test Plan:
- Three half coins (pulses at cycles 0, 10, 20), core returns cola on the third -> core_half pulses at cycles 2, 12, 22; disp_req rises at cycle 24; disp_ack at 30 -> disp_req low at cycle 31, change_req never asserted.
- half+one coincident at cycle 0 -> core_half in cycle 2, core_one in cycle 5; never both high together.
- Core returns core_cola=1 and core_money=1 -> disp_req until ack, then change_req until change_ack, then IDLE; busy low 1 cycle after change_ack is sampled.
- FIFO_DEPTH=4: queue filled to 3 while in DISPENSE, then coincident half+one -> half accepted, coin_rej_one pulses 1 cycle later, fifo_cnt=4.
- rst_n asserted while disp_req=1 with 2 coins queued -> disp_req, fifo_cnt and busy 0 immediately. After release there are no core pulses until new coins arrive.
- With STAT_VEND_CNT_EN, 3 complete vends -> vend_cnt=3. Without it, vend_cnt stays 0.
